// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle RV32I control FSM with memory-timeout/illegal traps; MULTICYCLE_PERF_CNT_EN adds perf counters
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      inst_i,
  input  logic             br_less_i,
  input  logic             br_equal_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [2:0]       mem_size_o,
  output logic             pc_we_o,
  output logic             br_sel_o,
  output logic             rd_wren_o,
  output logic             br_unsigned_o,
  output logic             op_a_sel_o,
  output logic             op_b_sel_o,
  output logic [3:0]       alu_op_o,
  output logic [1:0]       wb_sel_o,
  output logic             trap_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_OR = 4'd5, ALU_AND = 4'd6, ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASS_B = 4'd10;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              at_limit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_nz, illegal, taken;
  logic       is_branch, is_jump, is_load, is_store;
  logic [3:0] dec_alu_op;
  logic       dec_op_a, dec_op_b, dec_br_uns;
  logic [1:0] dec_wb_sel;
  logic       alu_en;
  logic       unused_inst_bits;

  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign funct7    = inst_i[31:25];
  assign rd_nz     = |inst_i[11:7];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign taken     = funct3[2] ? (br_less_i ^ funct3[0]) : (br_equal_i ^ funct3[0]);
  assign at_limit  = (MEM_TIMEOUT > 0) && (wait_cnt_q == WAIT_LAST);
  assign unused_inst_bits = ^inst_i[24:15];

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: illegal = 1'b0;
      OP_JALR:   illegal = (funct3 != 3'b000);
      OP_LOAD:   illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OP_STORE:  illegal = (funct3 >= 3'b011);
      OP_BRANCH: illegal = (funct3[2:1] == 2'b01);
      OP_OP:     illegal = !((funct7 == 7'h00) ||
                             ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      OP_OPIMM: begin
        if (funct3 == 3'b001)      illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101) illegal = !((funct7 == 7'h00) || (funct7 == 7'h20));
      end
      default:   illegal = 1'b1;
    endcase
  end

  // Datapath controls per instruction class; only presented to the outputs in EXEC/MEM/WB.
  always_comb begin
    dec_alu_op = ALU_ADD;
    dec_op_a   = 1'b0;
    dec_op_b   = 1'b0;
    dec_br_uns = 1'b0;
    dec_wb_sel = 2'b00;
    case (opcode)
      OP_OP, OP_OPIMM: begin
        dec_op_b = (opcode == OP_OPIMM);
        case (funct3)
          3'b000: dec_alu_op = ((opcode == OP_OP) && inst_i[30]) ? ALU_SUB : ALU_ADD;
          3'b001: dec_alu_op = ALU_SLL;
          3'b010: dec_alu_op = ALU_SLT;
          3'b011: begin
            dec_alu_op = ALU_SLTU;
            dec_br_uns = 1'b1;
          end
          3'b100: dec_alu_op = ALU_XOR;
          3'b101: dec_alu_op = inst_i[30] ? ALU_SRA : ALU_SRL;
          3'b110: dec_alu_op = ALU_OR;
          default: dec_alu_op = ALU_AND;
        endcase
      end
      OP_LUI: begin
        dec_alu_op = ALU_PASS_B;
        dec_op_b   = 1'b1;
      end
      OP_AUIPC: begin
        dec_op_a   = 1'b1;
        dec_op_b   = 1'b1;
        dec_wb_sel = 2'b01;
      end
      OP_JAL: begin
        dec_op_a   = 1'b1;
        dec_op_b   = 1'b1;
        dec_wb_sel = 2'b10;
      end
      OP_JALR: begin
        dec_op_b   = 1'b1;
        dec_wb_sel = 2'b10;
      end
      OP_BRANCH: begin
        dec_op_a   = 1'b1;
        dec_op_b   = 1'b1;
        dec_br_uns = funct3[1];
      end
      OP_LOAD: begin
        dec_op_b   = 1'b1;
        dec_wb_sel = 2'b11;
      end
      OP_STORE: dec_op_b = 1'b1;
      default: dec_op_b = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    imem_req_o    = 1'b0;
    ir_we_o       = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    mem_size_o    = 3'b000;
    pc_we_o       = 1'b0;
    br_sel_o      = 1'b0;
    rd_wren_o     = 1'b0;
    br_unsigned_o = 1'b0;
    op_a_sel_o    = 1'b0;
    op_b_sel_o    = 1'b0;
    alu_op_o      = 4'd0;
    wb_sel_o      = 2'b00;
    alu_en        = 1'b0;
    trap_o        = (state_q == TRAP);
    busy_o        = (state_q != TRAP);
    case (state_q)
      FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_ready_i;
        if (imem_ready_i)  state_d = DECODE;
        else if (at_limit) state_d = TRAP;
      end
      DECODE: state_d = illegal ? TRAP : EXEC;
      EXEC: begin
        alu_en = 1'b1;
        if (is_branch) begin
          pc_we_o  = 1'b1;
          br_sel_o = taken;
          state_d  = FETCH;
        end else if (is_jump) begin
          pc_we_o   = 1'b1;
          br_sel_o  = 1'b1;
          rd_wren_o = 1'b1;
          state_d   = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        alu_en     = 1'b1;
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        if (dmem_ready_i) begin
          pc_we_o = is_store;
          state_d = is_store ? FETCH : WB;
        end else if (at_limit) begin
          state_d = TRAP;
        end
      end
      WB: begin
        alu_en    = 1'b1;
        rd_wren_o = 1'b1;
        pc_we_o   = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = TRAP;
    endcase
    if (alu_en) begin
      alu_op_o      = dec_alu_op;
      op_a_sel_o    = dec_op_a;
      op_b_sel_o    = dec_op_b;
      br_unsigned_o = dec_br_uns;
      wb_sel_o      = dec_wb_sel;
      mem_size_o    = (is_load || is_store) ? funct3 : 3'b000;
    end
    rd_wren_o = rd_wren_o && rd_nz;
    // Reset silences every control so a half-finished access is dropped at once.
    if (rst_i) begin
      imem_req_o    = 1'b0;
      ir_we_o       = 1'b0;
      dmem_req_o    = 1'b0;
      dmem_we_o     = 1'b0;
      mem_size_o    = 3'b000;
      pc_we_o       = 1'b0;
      br_sel_o      = 1'b0;
      rd_wren_o     = 1'b0;
      br_unsigned_o = 1'b0;
      op_a_sel_o    = 1'b0;
      op_b_sel_o    = 1'b0;
      alu_op_o      = 4'd0;
      wb_sel_o      = 2'b00;
      trap_o        = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Counts only while stalled in FETCH/MEM; any state change (ready, entry, trap) clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      wait_cnt_q <= '0;
    else if (((state_q == FETCH) || (state_q == MEM)) && (state_d == state_q))
      wait_cnt_q <= wait_cnt_q + 1'b1;
    else
      wait_cnt_q <= '0;
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      if (busy_o)  cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (pc_we_o) instret_q   <= instret_q + 1'b1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`else
  assign cycle_cnt_o = '0;
  assign instret_o   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - scoreboard bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

  localparam int CW = 16;
`ifdef MULTICYCLE_PERF_CNT_EN
  localparam int EXP_INSTRET = 10;
  localparam int EXP_CYCLES  = 40;
`else
  localparam int EXP_INSTRET = 0;
  localparam int EXP_CYCLES  = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [31:0]   inst_i = 32'h0;
  logic          br_less_i = 1'b0, br_equal_i = 1'b0;
  logic          imem_ready_i = 1'b0, dmem_ready_i = 1'b0;
  logic          imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o, br_sel_o, rd_wren_o;
  logic          br_unsigned_o, op_a_sel_o, op_b_sel_o, trap_o, busy_o;
  logic [2:0]    mem_size_o;
  logic [3:0]    alu_op_o;
  logic [1:0]    wb_sel_o;
  logic [CW-1:0] cycle_cnt_o, instret_o;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i),
    .br_less_i(br_less_i), .br_equal_i(br_equal_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .imem_req_o(imem_req_o), .ir_we_o(ir_we_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .mem_size_o(mem_size_o), .pc_we_o(pc_we_o),
    .br_sel_o(br_sel_o), .rd_wren_o(rd_wren_o), .br_unsigned_o(br_unsigned_o),
    .op_a_sel_o(op_a_sel_o), .op_b_sel_o(op_b_sel_o), .alu_op_o(alu_op_o),
    .wb_sel_o(wb_sel_o), .trap_o(trap_o), .busy_o(busy_o),
    .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] cyc;
    logic [3:0] imem;
    logic [3:0] dmem;
    logic [3:0] dwe;
    logic [3:0] rdw;
    logic       pc_we;
    logic       br_sel;
    logic       br_uns;
    logic [3:0] alu;
    logic       op_a;
    logic       op_b;
    logic [1:0] wb;
    logic [2:0] msz;
    logic       trap;
    logic       busy;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic snap_t mk(int cyc, int imem, int dmem, int dwe, int rdw, bit pc, bit bs,
                               bit bu, int alu, bit oa, bit ob, int wb, int msz, bit trap, bit busy);
    snap_t s;
    s.cyc = 8'(cyc); s.imem = 4'(imem); s.dmem = 4'(dmem); s.dwe = 4'(dwe); s.rdw = 4'(rdw);
    s.pc_we = pc; s.br_sel = bs; s.br_uns = bu; s.alu = 4'(alu); s.op_a = oa; s.op_b = ob;
    s.wb = 2'(wb); s.msz = 3'(msz); s.trap = trap; s.busy = busy;
    return s;
  endfunction

  // Instruction retiring through WB with no memory access.
  function automatic snap_t wb_exp(int cyc, int imem, int rdw, int alu, bit oa, bit ob, bit bu, int wb);
    return mk(cyc, imem, 0, 0, rdw, 1, 0, bu, alu, oa, ob, wb, 0, 0, 1);
  endfunction

  function automatic snap_t trap_exp(int cyc, int imem);
    return mk(cyc, imem, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: accumulates per-instruction activity, compares on each retire (pc_we) or trap entry.
  initial begin
    int    acc_cyc, acc_imem, acc_dmem, acc_dwe, acc_rdw;
    bit    trap_seen;
    snap_t act, req;
    string nm;
    acc_cyc = 0; acc_imem = 0; acc_dmem = 0; acc_dwe = 0; acc_rdw = 0; trap_seen = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        acc_cyc = 0; acc_imem = 0; acc_dmem = 0; acc_dwe = 0; acc_rdw = 0; trap_seen = 0;
      end else begin
        if (busy_o) acc_cyc++;
        acc_imem += int'(imem_req_o);
        acc_dmem += int'(dmem_req_o);
        acc_dwe  += int'(dmem_we_o);
        acc_rdw  += int'(rd_wren_o);
        if (pc_we_o || (trap_o && !trap_seen)) begin
          if (trap_o) trap_seen = 1;
          act = mk(acc_cyc, acc_imem, acc_dmem, acc_dwe, acc_rdw, pc_we_o, br_sel_o, br_unsigned_o,
                   int'(alu_op_o), op_a_sel_o, op_b_sel_o, int'(wb_sel_o), int'(mem_size_o),
                   trap_o, busy_o);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %h, expected no event", act);
          end else begin
            req = exp_q.pop_front();
            nm  = name_q.pop_front();
            if (act !== req) begin
              n_fail++;
              $display("FAIL %s: got %h, expected %h", nm, act, req);
            end
          end
          acc_cyc = 0; acc_imem = 0; acc_dmem = 0; acc_dwe = 0; acc_rdw = 0;
        end
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_instr(input logic [31:0] inst, input int iw, input int dw,
                           input logic eq, input logic lt, input snap_t e, input string nm);
    int fcnt, dcnt;
    bit done;
    exp_q.push_back(e);
    name_q.push_back(nm);
    inst_i = inst; br_equal_i = eq; br_less_i = lt;
    fcnt = 0; dcnt = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      imem_ready_i = imem_req_o && (fcnt == iw);
      if (imem_req_o) fcnt++;
      dmem_ready_i = dmem_req_o && (dcnt == dw);
      if (dmem_req_o) dcnt++;
      #1;
      done = pc_we_o || trap_o;
      @(posedge clk_i);
      #1;
    end
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
    check({nm, "_completes"}, 64'(done), 64'(1));
  endtask

  task automatic do_reset();
    rst_i = 1'b1; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    @(negedge clk_i);
    check("reset_outputs_zero",
          64'({imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o, rd_wren_o, br_sel_o,
               br_unsigned_o, op_a_sel_o, op_b_sel_o, alu_op_o, mem_size_o, wb_sel_o, trap_o}), 64'(0));
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check("post_reset_fetch", 64'({imem_req_o, dmem_req_o, trap_o, busy_o}), 64'(4'b1001));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    run_instr(32'h00500093, 0, 0, 0, 0, wb_exp(4, 1, 1, 0, 0, 1, 0, 0), "addi");
    run_instr(32'h00000463, 0, 0, 1, 0, mk(3, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1), "beq_taken");
    run_instr(32'h00000463, 0, 0, 0, 0, mk(3, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1), "beq_not_taken");
    run_instr(32'h00007463, 0, 0, 0, 0, mk(3, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 1), "bgeu_taken");
    run_instr(32'h0020A023, 0, 2, 0, 0, mk(6, 1, 3, 3, 0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 1), "sw_wait");
    run_instr(32'h0000C283, 0, 0, 0, 0, mk(5, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 3, 4, 0, 1), "lbu");
    run_instr(32'h00500093, 3, 0, 0, 0, wb_exp(7, 4, 1, 0, 0, 1, 0, 0), "ready_at_limit");
    run_instr(32'h00208033, 0, 0, 0, 0, wb_exp(4, 1, 0, 0, 0, 0, 0, 0), "add_rd_x0");
    run_instr(32'h402081B3, 0, 0, 0, 0, wb_exp(4, 1, 1, 1, 0, 0, 0, 0), "sub");
    run_instr(32'h00001217, 0, 0, 0, 0, wb_exp(4, 1, 1, 0, 1, 1, 0, 1), "auipc");
    run_instr(32'h008000EF, 0, 0, 0, 0, mk(3, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 2, 0, 0, 1), "jal");
    run_instr(32'h4020D093, 0, 0, 0, 0, wb_exp(4, 1, 1, 9, 0, 1, 0, 0), "srai");
    run_instr(32'h0020B0B3, 0, 0, 0, 0, wb_exp(4, 1, 1, 3, 0, 0, 1, 0), "sltu");
    run_instr(32'h123450B7, 0, 0, 0, 0, wb_exp(4, 1, 1, 10, 0, 1, 0, 0), "lui");

    run_instr(32'h00500093, 1000, 0, 0, 0, trap_exp(4, 4), "fetch_timeout");
    check("trap_held", 64'({trap_o, busy_o, imem_req_o}), 64'(3'b100));
    do_reset();
    run_instr(32'h0000007F, 0, 0, 0, 0, trap_exp(2, 1), "illegal_opcode");
    do_reset();
    run_instr(32'h022081B3, 0, 0, 0, 0, trap_exp(2, 1), "illegal_funct7");
    do_reset();

    inst_i = 32'h0020A023;
    imem_ready_i = 1'b1;
    @(posedge clk_i); #1 imem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("mem_req_before_abort", 64'({dmem_req_o, dmem_we_o}), 64'(2'b11));
    do_reset();

    for (int i = 0; i < 10; i++)
      run_instr(32'h00500093, 0, 0, 0, 0, wb_exp(4, 1, 1, 0, 0, 1, 0, 0), "addi_perf");
    check("instret", 64'(instret_o), 64'(EXP_INSTRET));
    check("cycle_cnt", 64'(cycle_cnt_o), 64'(EXP_CYCLES));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
